uart_if_param: RTL and testbench
================================

// Module: uart_if_param
// PURPOSE
//   Parametrised successor to the fixed 8N1 UART interface. Full-duplex UART with a configurable frame
//   (data bits, parity, stop bits), an RX FIFO, and error reporting. Runtime echo_en either loops
//   received bytes back onto txd, or exposes the RX FIFO and TX path to host logic through
//   valid/ready streams. Sits between the board serial pins and the on-chip command logic.
// PARAMETERS
//   CLKS_PER_BIT  108  clk cycles per bit (100 MHz / 921600 baud); >= 8
//   DATA_BITS     8    data bits per frame, 5..9, sent and received LSB first
//   PARITY        0    0 = none, 1 = odd, 2 = even
//   STOP_BITS     1    TX stop bits, 1 or 2; RX checks only the first stop bit
//   FIFO_DEPTH    16   RX FIFO entries, power of 2, >= 2
// PORTS
//   clk        in   1                     system clock
//   rstb       in   1                     asynchronous active-low reset
//   rxd        in   1                     serial input (asynchronous to clk; idles high)
//   txd        out  1                     serial output (idles high)
//   echo_en    in   1                     1 = loopback RX FIFO to TX; 0 = host mode
//   rx_data    out  DATA_BITS             head of RX FIFO (show-ahead)
//   rx_valid   out  1                     FIFO non-empty and echo_en = 0
//   rx_ready   in   1                     host pops the FIFO when rx_valid & rx_ready
//   tx_data    in   DATA_BITS             host byte to transmit
//   tx_valid   in   1                     host offers tx_data
//   tx_ready   out  1                     (TX idle) & !echo_en; accept on tx_valid & tx_ready
//   fifo_level out  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy
//   frm_err    out  1                     1-cycle pulse: first stop bit sampled low
//   par_err    out  1                     1-cycle pulse: parity mismatch
//   ovr_err    out  1                     1-cycle pulse: good frame dropped because the FIFO is full
// BEHAVIOUR
//   Reset (async, while rstb = 0): txd = 1; rx_valid = 0; rx_data = 0; fifo_level = 0;
//     all error pulses = 0; both FSMs in IDLE; FIFO pointers cleared.
//     tx_ready = !echo_en immediately after release.
//   rxd synchroniser: 2 flops. All RX timing below is in synchronised-sample cycles.
//   RX FSM states: IDLE -> START -> DATA -> PARITY (only if PARITY != 0) -> STOP -> IDLE.
//     IDLE: on a synced 0, go to START and count CLKS_PER_BIT/2 cycles.
//     START: mid-bit sample; if 1, the low was a glitch -> IDLE with no error.
//     DATA/PARITY/STOP: sample every CLKS_PER_BIT cycles at mid-bit.
//     At the STOP sample (exactly one of the following):
//       - stop = 0: frm_err pulse, byte discarded, FSM waits for rxd = 1 before IDLE (break tolerant).
//       - parity mismatch: par_err pulse, byte discarded.
//       - otherwise push the byte; if the FIFO is full with no pop this cycle: ovr_err pulse, byte dropped.
//     Frame error takes priority over parity error.
//   FIFO: show-ahead. Push and pop in the same cycle leaves the level unchanged.
//     Full + pop + push in the same cycle: push accepted, no ovr_err.
//     rx_data bits above DATA_BITS do not exist; rx_data is exactly DATA_BITS wide.
//   TX FSM states: IDLE -> START -> DATA -> PARITY (optional) -> STOP (STOP_BITS x) -> IDLE.
//     Each bit is held exactly CLKS_PER_BIT cycles.
//     Host mode: the accept cycle is t; txd = 0 from t+1.
//     Echo mode: in IDLE with the FIFO non-empty, pop at t; txd = 0 from t+1.
//       Echo latency is 2 cycles from the RX stop-sample push to the txd falling edge.
//     Back-to-back frames: the next start bit immediately follows the last stop bit; no idle cycle.
//     Parity bit = XOR of the data bits (even) or its inverse (odd).
//   echo_en changes: sampled only while TX is in IDLE. An in-flight frame always completes.
//     FIFO contents are preserved across a change.
//   Reset mid-frame: txd goes to 1 asynchronously; FIFO contents are lost; a partial RX frame is discarded.
// TESTING
//   1. echo_en=1; drive frames 0x59 then 0x6B back-to-back at 108 clk/bit
//      -> txd replays 0x59 then 0x6B, 8N1, each start bit 2 cycles after the matching RX stop sample.
//   2. echo_en=0, PARITY=2; tx_data=0xA5 handshake
//      -> txd = 0,1,0,1,0,0,1,0,1,0(parity),1, each bit 108 cycles; tx_ready=0 until stop bit ends.
//   3. Frame 0x4D with stop=0, rxd held low 3 bit-times then released, then a valid 0x4D
//      -> one frm_err pulse, no push; then rx_data=0x4D, fifo_level=1.
//   4. echo_en=0, rx_ready=0; send 17 frames 0x00..0x10
//      -> fifo_level=16, ovr_err on the 17th frame; pops return 0x00..0x0F in order.
//   5. rxd low for 20 cycles, then high
//      -> no FIFO push, no error pulses, RX back in IDLE.
//   6. rstb=0 during TX data bit 3 with 4 bytes queued
//      -> txd=1 in the same timestep, fifo_level=0; after release tx_ready=1 with echo_en=0.

Source files
------------

// File: rtl/uart_if_param.sv
`default_nettype none
// uart_if_param -- full-duplex UART, configurable frame, show-ahead RX FIFO, echo/host modes.
// Rev 1.0
module uart_if_param #(
  parameter int CLKS_PER_BIT = 108,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rstb,
  input  logic                        rxd,
  output logic                        txd,
  input  logic                        echo_en,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        frm_err,
  output logic                        par_err,
  output logic                        ovr_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] C_BIT_M1    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] C_LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          C_LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic          C_ODD       = (PARITY == 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_BREAK} rx_state_e;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_e;

  logic rxd_s1_q, rxd_s2_q;

  rx_state_e            rx_st_q, rx_st_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_par_q, rx_par_d;
  logic                 frm_err_q, frm_err_d, par_err_q, par_err_d, ovr_err_q, ovr_err_d;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          level_q;
  logic                 push_req, push, pop, empty, full;

  tx_state_e            tx_st_q, tx_st_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d, tx_src;
  logic                 tx_par_q, tx_par_d, tx_stop_q, tx_stop_d, txd_q, txd_d;
  logic                 tx_last, tx_idle, tx_start;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
    end else begin
      rxd_s1_q <= rxd;
      rxd_s2_q <= rxd_s1_q;
    end
  end

  always_comb begin
    rx_st_d   = rx_st_q;
    rx_cnt_d  = rx_cnt_q;
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    rx_par_d  = rx_par_q;
    push_req  = 1'b0;
    frm_err_d = 1'b0;
    par_err_d = 1'b0;
    case (rx_st_q)
      R_IDLE: if (!rxd_s2_q) begin
        rx_st_d  = R_START;
        rx_cnt_d = C_HALF_M1;
      end
      R_START: if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
        else if (rxd_s2_q) rx_st_d = R_IDLE;
        else begin
          rx_st_d  = R_DATA;
          rx_cnt_d = C_BIT_M1;
          rx_bit_d = '0;
        end
      R_DATA: if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
        else begin
          rx_sh_d  = {rxd_s2_q, rx_sh_q[DATA_BITS-1:1]};
          rx_cnt_d = C_BIT_M1;
          if (rx_bit_q == C_LAST_BIT) rx_st_d = (PARITY != 0) ? R_PARITY : R_STOP;
          else rx_bit_d = rx_bit_q + 1'b1;
        end
      R_PARITY: if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
        else begin
          rx_par_d = rxd_s2_q;
          rx_cnt_d = C_BIT_M1;
          rx_st_d  = R_STOP;
        end
      R_STOP: if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
        else if (!rxd_s2_q) begin
          // Line held low through the stop bit: wait out a possible break before re-arming.
          frm_err_d = 1'b1;
          rx_st_d   = R_BREAK;
        end else begin
          rx_st_d = R_IDLE;
          if ((PARITY != 0) && (rx_par_q != ((^rx_sh_q) ^ C_ODD))) par_err_d = 1'b1;
          else push_req = 1'b1;
        end
      R_BREAK: if (rxd_s2_q) rx_st_d = R_IDLE;
      default: rx_st_d = R_IDLE;
    endcase
  end

  assign empty     = (level_q == '0);
  assign full      = (level_q == (AW+1)'(FIFO_DEPTH));
  assign pop       = echo_en ? tx_start : (!empty && rx_ready);
  assign push      = push_req && (!full || pop);
  assign ovr_err_d = push_req && full && !pop;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rx_st_q   <= R_IDLE;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_par_q  <= 1'b0;
      frm_err_q <= 1'b0;
      par_err_q <= 1'b0;
      ovr_err_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
    end else begin
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      rx_par_q  <= rx_par_d;
      frm_err_q <= frm_err_d;
      par_err_q <= par_err_d;
      ovr_err_q <= ovr_err_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_sh_q;
  end

  assign rx_data    = empty ? '0 : mem_q[rd_ptr_q];
  assign rx_valid   = !empty && !echo_en;
  assign fifo_level = level_q;
  assign frm_err    = frm_err_q;
  assign par_err    = par_err_q;
  assign ovr_err    = ovr_err_q;

  // The last stop-bit cycle counts as idle so a queued frame starts with no gap.
  assign tx_last  = (tx_cnt_q == '0);
  assign tx_idle  = (tx_st_q == T_IDLE) ||
                    ((tx_st_q == T_STOP) && tx_last && (tx_stop_q == C_LAST_STOP));
  assign tx_start = tx_idle && (echo_en ? !empty : tx_valid);
  assign tx_src   = echo_en ? rx_data : tx_data;
  assign tx_ready = tx_idle && !echo_en;

  always_comb begin
    tx_st_d   = tx_st_q;
    tx_cnt_d  = tx_last ? C_BIT_M1 : tx_cnt_q - 1'b1;
    tx_bit_d  = tx_bit_q;
    tx_sh_d   = tx_sh_q;
    tx_par_d  = tx_par_q;
    tx_stop_d = tx_stop_q;
    txd_d     = txd_q;
    case (tx_st_q)
      T_START: if (tx_last) begin
        tx_st_d  = T_DATA;
        tx_bit_d = '0;
        txd_d    = tx_sh_q[0];
        tx_sh_d  = tx_sh_q >> 1;
      end
      T_DATA: if (tx_last) begin
        if (tx_bit_q != C_LAST_BIT) begin
          tx_bit_d = tx_bit_q + 1'b1;
          txd_d    = tx_sh_q[0];
          tx_sh_d  = tx_sh_q >> 1;
        end else if (PARITY != 0) begin
          tx_st_d = T_PARITY;
          txd_d   = tx_par_q;
        end else begin
          tx_st_d   = T_STOP;
          txd_d     = 1'b1;
          tx_stop_d = 1'b0;
        end
      end
      T_PARITY: if (tx_last) begin
        tx_st_d   = T_STOP;
        txd_d     = 1'b1;
        tx_stop_d = 1'b0;
      end
      T_STOP: if (tx_last) begin
        if (tx_stop_q == C_LAST_STOP) tx_st_d = T_IDLE;
        else tx_stop_d = 1'b1;
      end
      default: ;
    endcase
    if (tx_start) begin
      tx_st_d  = T_START;
      tx_cnt_d = C_BIT_M1;
      tx_sh_d  = tx_src;
      tx_par_d = (^tx_src) ^ C_ODD;
      txd_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      tx_st_q   <= T_IDLE;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      tx_par_q  <= 1'b0;
      tx_stop_q <= 1'b0;
      txd_q     <= 1'b1;
    end else begin
      tx_st_q   <= tx_st_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      tx_par_q  <= tx_par_d;
      tx_stop_q <= tx_stop_d;
      txd_q     <= txd_d;
    end
  end

  assign txd = txd_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_if_param.sv
`default_nettype none
// tb_uart_if_param -- scoreboard bench: echo replay, host TX with parity, RX errors, FIFO, reset.
module tb_uart_if_param;
  localparam int CPB = 108;

  logic       clk = 1'b0, rstb = 1'b0;
  logic       rxd = 1'b1, echo_en = 1'b0, rx_ready = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic       txd, rx_valid, tx_ready, frm_err, par_err, ovr_err;
  logic [7:0] rx_data;
  logic [4:0] fifo_level;

  logic       rxd_p = 1'b1, tx_valid_p = 1'b0;
  logic [7:0] tx_data_p = '0;
  logic       txd_p, rx_valid_p, tx_ready_p, frm_err_p, par_err_p, ovr_err_p;
  logic [7:0] rx_data_p;
  logic [4:0] fifo_level_p;

  int cyc = 0, n_tests = 0, n_fail = 0;
  int frm_cnt = 0, par_cnt = 0, ovr_cnt = 0, pe_cnt_p = 0;
  logic [7:0] exp_tx_q[$];
  int         exp_fall_q[$];
  logic [7:0] rx_q[$];

  uart_if_param u_dut (
    .clk(clk), .rstb(rstb), .rxd(rxd), .txd(txd), .echo_en(echo_en),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fifo_level(fifo_level), .frm_err(frm_err), .par_err(par_err), .ovr_err(ovr_err)
  );

  uart_if_param #(.PARITY(2)) u_dut_p (
    .clk(clk), .rstb(rstb), .rxd(rxd_p), .txd(txd_p), .echo_en(1'b0),
    .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(1'b0),
    .tx_data(tx_data_p), .tx_valid(tx_valid_p), .tx_ready(tx_ready_p),
    .fifo_level(fifo_level_p), .frm_err(frm_err_p), .par_err(par_err_p), .ovr_err(ovr_err_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (frm_err)   frm_cnt++;
    if (par_err)   par_cnt++;
    if (ovr_err)   ovr_cnt++;
    if (par_err_p) pe_cnt_p++;
  end

  initial begin
    #(70000 * 10);
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] frame8(input logic [7:0] b, input logic stop);
    return {2'b11, stop, b, 1'b0};
  endfunction

  function automatic logic [11:0] frame_even(input logic [7:0] b, input logic bad);
    return {1'b1, 1'b1, (^b) ^ bad, b, 1'b0};
  endfunction

  function automatic logic txsel(input bit s);
    return s ? txd_p : txd;
  endfunction

  function automatic logic rdysel(input bit s);
    return s ? tx_ready_p : tx_ready;
  endfunction

  // Echoed frames: expected txd fall = first edge after start + 2 sync + half bit + 9 bits + 2.
  task automatic send_bits(input bit sel, input logic [11:0] v, input int n, input bit sb);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (sel) rxd_p = v[k]; else rxd = v[k];
      if (k == 0 && sb) begin
        exp_tx_q.push_back(v[8:1]);
        exp_fall_q.push_back(cyc + 1 + 3 + CPB / 2 + 9 * CPB);
      end
      repeat (CPB - 1) @(negedge clk);
    end
  endtask

  task automatic capture_tx(input bit sel, input int nb, input int tmo, output logic [11:0] bits,
                            output int fall, output bit wok, output bit rdy);
    int   n;
    logic v;
    bits = '1; fall = -1; wok = 1'b0; rdy = 1'b0; n = 0;
    @(negedge clk);
    while (txsel(sel) !== 1'b0 && n < tmo) begin
      @(negedge clk);
      n++;
    end
    if (txsel(sel) !== 1'b0) return;
    fall = cyc;
    wok  = 1'b1;
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < CPB; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        v = txsel(sel);
        if (c == 0) bits[k] = v;
        else if (v !== bits[k]) wok = 1'b0;
        if (k != nb - 1 || c != CPB - 1) rdy = rdy | rdysel(sel);
      end
    end
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (rx_q.size() > 0) e = rx_q.pop_front();
    else e = 8'hxx;
    check({tag, "_valid"}, rx_valid, 1'b1);
    check({tag, "_data"}, rx_data, e);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    logic [11:0] bits;
    logic [7:0]  eb;
    int          fall, ef, base;
    bit          wok, rdy;

    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_level", fifo_level, 5'd0);
    check("rst_errs", {frm_err, par_err, ovr_err}, 3'b000);
    rstb = 1'b1;
    @(negedge clk);
    check("rst_tx_ready", tx_ready, 1'b1);

    echo_en = 1'b1;
    #1 check("echo_tx_ready", tx_ready, 1'b0);
    fork
      begin
        send_bits(0, frame8(8'h59, 1'b1), 10, 1'b1);
        send_bits(0, frame8(8'h6B, 1'b1), 10, 1'b1);
      end
      begin
        for (int i = 0; i < 2; i++) begin
          capture_tx(0, 10, 30 * CPB, bits, fall, wok, rdy);
          if (exp_tx_q.size() > 0) begin
            eb = exp_tx_q.pop_front();
            ef = exp_fall_q.pop_front();
          end else begin
            eb = 8'hxx;
            ef = -2;
          end
          check("echo_byte", bits[8:1], eb);
          check("echo_start_stop", {bits[9], bits[0]}, 2'b10);
          check("echo_latency", fall, ef);
          check("echo_bit_width", wok, 1'b1);
        end
      end
    join
    repeat (4) @(negedge clk);
    echo_en = 1'b0;
    check("echo_drained", fifo_level, 5'd0);

    rxd = 1'b0;
    repeat (20) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("glitch_level", fifo_level, 5'd0);
    check("glitch_errs", frm_cnt + par_cnt + ovr_cnt, 0);

    send_bits(0, frame8(8'h4D, 1'b0), 10, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (CPB) @(negedge clk);
    check("frm_pulse", frm_cnt, 1);
    check("frm_no_push", fifo_level, 5'd0);
    send_bits(0, frame8(8'h4D, 1'b1), 10, 1'b0);
    rx_q.push_back(8'h4D);
    repeat (8) @(negedge clk);
    check("frm_recover_level", fifo_level, 5'd1);
    check("frm_single_pulse", frm_cnt, 1);
    pop_check("frm_recover");

    base = ovr_cnt;
    for (int i = 0; i <= 16; i++) begin
      send_bits(0, frame8(8'(i), 1'b1), 10, 1'b0);
      if (i < 16) rx_q.push_back(8'(i));
    end
    repeat (8) @(negedge clk);
    check("full_level", fifo_level, 5'd16);
    check("ovr_pulse", ovr_cnt - base, 1);
    for (int i = 0; i < 16; i++) pop_check("fifo_pop");
    check("fifo_empty_valid", rx_valid, 1'b0);
    check("fifo_empty_level", fifo_level, 5'd0);

    for (int i = 0; i < 4; i++) send_bits(0, frame8(8'h11 + 8'(i), 1'b1), 10, 1'b0);
    repeat (8) @(negedge clk);
    check("pre_rst_level", fifo_level, 5'd4);
    tx_data  = 8'hF0;
    tx_valid = 1'b1;
    check("host_tx_ready", tx_ready, 1'b1);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    check("pre_rst_txd", txd, 1'b0);
    #2 rstb = 1'b0;
    #1;
    check("mid_rst_txd", txd, 1'b1);
    check("mid_rst_level", fifo_level, 5'd0);
    check("mid_rst_valid", rx_valid, 1'b0);
    rx_q.delete();
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    check("post_rst_tx_ready", tx_ready, 1'b1);

    @(negedge clk);
    tx_data_p  = 8'hA5;
    tx_valid_p = 1'b1;
    check("ptx_ready", tx_ready_p, 1'b1);
    ef = cyc + 1;
    fork
      begin
        @(negedge clk);
        tx_valid_p = 1'b0;
      end
      capture_tx(1, 11, 4 * CPB, bits, fall, wok, rdy);
    join
    check("ptx_bits", bits[10:0], {1'b1, ^8'hA5, 8'hA5, 1'b0});
    check("ptx_latency", fall, ef);
    check("ptx_bit_width", wok, 1'b1);
    check("ptx_busy_ready", rdy, 1'b0);
    @(negedge clk);
    check("ptx_ready_after", tx_ready_p, 1'b1);

    base = pe_cnt_p;
    send_bits(1, frame_even(8'h3C, 1'b1), 11, 1'b0);
    repeat (8) @(negedge clk);
    check("par_pulse", pe_cnt_p - base, 1);
    check("par_no_push", fifo_level_p, 5'd0);
    send_bits(1, frame_even(8'h96, 1'b0), 11, 1'b0);
    repeat (8) @(negedge clk);
    check("par_good_level", fifo_level_p, 5'd1);
    check("par_good_data", rx_data_p, 8'h96);
    check("nopar_no_par_err", par_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
